// File: rtl/serial_add_sub_pkg.sv
// serial_add_sub_pkg
//   Shared definitions for the bit-serial adder/subtractor:
//   - state_t       : controller state encoding (IDLE, RUN, DONE)
//   - DEFAULT_WIDTH : default operand/result width
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// full_adder
//   Combinational 1-bit full adder, reusable as the arithmetic slice of any
//   bit-serial datapath.
//   Ports:
//     a, b  : input  operand bits
//     cin   : input  carry in
//     sum   : output a ^ b ^ cin
//     cout  : output carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub
//   Bit-serial adder/subtractor. One full-adder slice is iterated LSB-first
//   over WIDTH cycles. Subtraction is a + ~b + 1, with the +1 entering as the
//   initial carry.
//   Ports:
//     clk      : input  rising-edge clock
//     rst_n    : input  asynchronous active-low reset
//     start    : input  request, sampled in IDLE or DONE
//     sub      : input  0 = a+b, 1 = a-b (sampled with start)
//     a, b     : input  WIDTH-bit operands (sampled with start)
//     busy     : output high while the serial computation runs
//     done     : output one-cycle pulse, result registers valid
//     sum      : output WIDTH-bit result, held until the next completion
//     carry    : output carry-out (add) / no-borrow (sub)
//     overflow : output two's-complement signed overflow
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-2:0] sh_s;   // partial result; bit WIDTH-1 is the live adder output
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic             a_msb;
  logic             b_msb;  // MSB of the effective (possibly inverted) B
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] sh_next;

  full_adder u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (c),
    .sum  (fa_s),
    .cout (fa_co)
  );

  // New sum bit enters at the top; on the last step this is the full result.
  assign sh_next = {fa_s, sh_s};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sh_a     <= '0;
      sh_b     <= '0;
      sh_s     <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= sub ? ~b : b;
            c     <= sub;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1] ^ sub;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sh_s <= sh_next[WIDTH-1:1];
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          c    <= fa_co;
          if (cnt == CNT_LAST) begin
            sum      <= sh_next;
            carry    <= fa_co;
            // Same-sign operands producing a result of the other sign.
            overflow <= (a_msb == b_msb) && (fa_s != a_msb);
            state    <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start, sub;
  logic [15:0] a, b;
  logic        busy, done, carry, overflow;
  logic [15:0] sum;

  logic        start4, sub4;
  logic [3:0]  a4, b4;
  logic        busy4, done4, carry4, overflow4;
  logic [3:0]  sum4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .carry(carry), .overflow(overflow)
  );

  serial_add_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4), .overflow(overflow4)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          sub;
    logic [15:0] exp_sum;
    bit          exp_carry;
    bit          exp_ovf;
    string       name;
  } vec_t;

  // Arithmetic reference: modulo-2^w result, unsigned carry/no-borrow,
  // signed overflow from the true signed result leaving the w-bit range.
  function automatic void model(input int w, input logic [31:0] x, input logic [31:0] y,
                                input bit s, output logic [31:0] r, output bit c, output bit v);
    longint m, ux, uy, sx, sy, res, sres;
    m  = longint'(1) << w;
    ux = longint'(x) & (m - 1);
    uy = longint'(y) & (m - 1);
    sx = (ux >= m / 2) ? ux - m : ux;
    sy = (uy >= m / 2) ? uy - m : uy;
    if (s) begin
      res  = ux - uy;
      c    = (ux >= uy);
      sres = sx - sy;
    end else begin
      res  = ux + uy;
      c    = (res >= m);
      sres = sx + sy;
    end
    r = 32'(res & (m - 1));
    v = (sres >= m / 2) || (sres < -(m / 2));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic run_op16(input logic [15:0] ta, input logic [15:0] tb_b, input bit ts,
                          input logic [15:0] es, input bit ec, input bit ev, input string nm);
    int edges, busy_cnt;
    a = ta; b = tb_b; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0; busy_cnt = 0;
    // Operands are scrambled during RUN; the result must not notice.
    while (!done && edges < 100) begin
      if (busy) busy_cnt++;
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      edges++;
    end
    chk({nm, "_latency"}, edges, 16);
    chk({nm, "_busy_cycles"}, busy_cnt, 16);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_carry"}, carry, ec);
    chk({nm, "_ovf"}, overflow, ev);
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, {busy, done}, 2'b00);
  endtask

  task automatic run_op4(input logic [3:0] ta, input logic [3:0] tb_b, input bit ts,
                         input logic [3:0] es, input bit ec, input bit ev, input string nm);
    int edges, busy_cnt;
    a4 = ta; b4 = tb_b; sub4 = ts; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    edges = 0; busy_cnt = 0;
    while (!done4 && edges < 100) begin
      if (busy4) busy_cnt++;
      @(posedge clk); #1;
      edges++;
    end
    chk({nm, "_latency"}, edges, 4);
    chk({nm, "_busy_cycles"}, busy_cnt, 4);
    chk({nm, "_sum"}, sum4, es);
    chk({nm, "_carry"}, carry4, ec);
    chk({nm, "_ovf"}, overflow4, ev);
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, done4, 1'b0);
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] r;
    bit          rc, rv;
    logic [15:0] ra, rb, pa, pb;
    bit          rs;
    int          edges, done_seen;

    vecs.push_back('{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "add_1_1"});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ffff_1"});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_7fff_1"});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "add_8000_8000"});
    vecs.push_back('{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_3_5"});
    vecs.push_back('{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_8000_1"});
    vecs.push_back('{16'h1234, 16'h0000, 1'b1, 16'h1234, 1'b1, 1'b0, "sub_b_zero"});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_equal"});

    // Reset with random activity on the inputs.
    rst_n = 1'b0;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    for (int i = 0; i < 5; i++) begin
      start = 1'($urandom); sub = 1'($urandom);
      a = 16'($urandom); b = 16'($urandom);
      start4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
      @(posedge clk); #1;
    end
    chk("reset_outputs16", {busy, done, sum, carry, overflow}, 20'h0);
    chk("reset_outputs4", {busy4, done4, sum4, carry4, overflow4}, 8'h0);
    start4 = 1'b0;
    rst_n = 1'b1;

    // First operation issued in the first cycle after release.
    foreach (vecs[i])
      run_op16(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp_sum,
               vecs[i].exp_carry, vecs[i].exp_ovf, vecs[i].name);

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      model(16, {16'h0, ra}, {16'h0, rb}, rs, r, rc, rv);
      run_op16(ra, rb, rs, r[15:0], rc, rv, $sformatf("rand16_%0d", i));
    end

    // Start held through RUN with operands changing: no restart, and the
    // next operation is captured on the DONE edge.
    ra = 16'h1357; rb = 16'h2468;
    a = ra; b = rb; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    edges = 0;
    while (!done && edges < 100) begin
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      edges++;
    end
    chk("held_latency", edges, 16);
    model(16, {16'h0, ra}, {16'h0, rb}, 1'b0, r, rc, rv);
    chk("held_result", {sum, carry, overflow}, {r[15:0], rc, rv});
    pa = 16'h0100; pb = 16'h0200;
    a = pa; b = pb; sub = 1'b1;
    @(posedge clk); #1;
    chk("held_restart_busy", {busy, done}, 2'b10);
    edges = 1;
    while (!done && edges < 100) begin
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      edges++;
    end
    chk("held_period", edges, 17);
    model(16, {16'h0, pa}, {16'h0, pb}, 1'b1, r, rc, rv);
    chk("held_result2", {sum, carry, overflow}, {r[15:0], rc, rv});
    start = 1'b0;
    @(posedge clk); #1;

    // Abort in the 8th RUN cycle.
    a = 16'h4321; b = 16'h1111; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
    end
    chk("abort_pre_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs", {busy, done, sum, carry, overflow}, 20'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    run_op16(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, "post_abort");

    // Small width.
    run_op4(4'h9, 4'h8, 1'b0, 4'h1, 1'b1, 1'b1, "w4_9_8");
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom_range(0, 15)); rb = 16'($urandom_range(0, 15)); rs = 1'($urandom);
      model(4, {16'h0, ra}, {16'h0, rb}, rs, r, rc, rv);
      run_op4(ra[3:0], rb[3:0], rs, r[3:0], rc, rv, $sformatf("rand4_%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Parametrised bit-serial adder/subtractor: one 1-bit full-adder slice, iterated LSB-first over WIDTH cycles.
- Start/busy/done handshake.
- Registered sum, carry and signed-overflow outputs.
- Sits between switch inputs and the hex display driver: sum feeds the display's 16-bit value input, carry and overflow drive LEDs.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result registers valid.
- sum  output  WIDTH  result; holds until next completion.
- carry  output  1  add: carry-out; sub: 1 = no borrow (a >= b unsigned).
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset: asynchronous on rst_n low, effective immediately in any state, including mid-RUN.
  - state=IDLE; busy=0, done=0, sum=0, carry=0, overflow=0.
  - Internal shift registers and counter cleared; the aborted operation never produces done.
- States IDLE, RUN, DONE. Outputs decode as busy = (state==RUN), done = (state==DONE).
- IDLE/DONE with start=1, at edge E0:
  - Load shA=a, shB = sub ? ~b : b.
  - c = sub; cnt = 0; state→RUN.
  - Capture a[WIDTH-1] and effective b[WIDTH-1] for the overflow calculation.
- IDLE with start=0: stay IDLE. DONE with start=0: →IDLE.
- RUN, each edge:
  - full_adder(shA[0], shB[0], c) → s, co.
  - shS = {s, shS[WIDTH-1:1]}; shA and shB shift right; c = co; cnt++.
- RUN, at the edge where cnt == WIDTH-1, which is edge E_WIDTH:
  - The final bit is computed as above.
  - sum = {s, shS[WIDTH-1:1]}; carry = co.
  - overflow = (aMSB == bEffMSB) && (s != aMSB).
  - state→DONE.
- Latency: done is high in the cycle after edge E_WIDTH, exactly WIDTH edges after the start-capture edge.
  - busy is high for exactly WIDTH cycles.
- Throughput: start held high gives back-to-back operations, one every WIDTH+1 cycles (start accepted while in DONE).
- start in RUN is ignored, including start held continuously. a, b and sub may change freely during RUN without effect.
- sum, carry and overflow change only at completion or reset.
- Counter width is clog2(WIDTH). There is no wrap-around beyond WIDTH-1.
- Edge cases: WIDTH-bit arithmetic modulo 2^WIDTH.
  - a-b with b=0 gives carry=1.
  - Most-negative minus 1 sets overflow.

Decomposition:
- Package serial_add_sub_pkg:
  - State encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default width constant 16.
- One natural sub-module: full_adder (combinational 1-bit a, b, cin → sum, cout). It is instantiated once and reusable by other exercises.

Test Plan (WIDTH=16 unless noted):
- Reset: rst_n low with random inputs → busy=0, done=0, sum=0x0000, carry=0, overflow=0; start in the first cycle after release is accepted.
- Add 0x0001+0x0001, sub=0 → busy high 16 cycles; done pulses exactly once, 16 edges after capture; sum=0x0002, carry=0, overflow=0.
- Add 0xFFFF+0x0001 → sum=0x0000, carry=1, overflow=0. Add 0x7FFF+0x0001 → sum=0x8000, carry=0, overflow=1.
- Subtract 0x0003-0x0005 → sum=0xFFFE, carry=0, overflow=0. Subtract 0x8000-0x0001 → sum=0x7FFF, carry=1, overflow=1.
- Protocol:
  - Pulse start, then toggle a/b/sub and hold start high during RUN → result matches the captured operands; no restart occurs mid-RUN.
  - Held start yields the next operation capturing at the DONE edge, with a period of 17 cycles.
- Abort and small width:
  - Assert rst_n low at the 8th RUN cycle → immediate IDLE, outputs 0, no done pulse; the next operation is correct.
  - Repeat with WIDTH=4, 0x9+0x8 → sum=0x1, carry=1, overflow=1, done 4 edges after capture.
